// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit -- iterative HI/LO multiply/divide unit
//
// One iteration per clock: a shift-add multiplier and, optionally, a
// restoring divider. Both work on operand magnitudes while in RUN, and
// sign correction is applied in the single FIX cycle. Results land in
// the registered HI/LO pair, which MTHI/MTLO can also load while idle.
//
// Configuration macro: MULDIV_DIV_EN
//   defined   -> divider built, ops 10 (DIV) and 11 (DIVU) supported
//   undefined -> no divider logic, start with op[1]=1 is ignored
//
// Ports
//   clk_i      clock, all state changes on its rising edge
//   reset_i    synchronous active-high reset
//   start_i    launch request, sampled only in IDLE
//   op_i       00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a_i, b_i   operands (dividend / divisor for divide ops)
//   hi_we_i    MTHI write enable (IDLE only)
//   lo_we_i    MTLO write enable (IDLE only)
//   wdata_i    MTHI/MTLO write data
//   busy_o     high while an operation is in flight
//   done_o     one-cycle completion pulse
//   hi_o, lo_o registered HI/LO values
// ---------------------------------------------------------------------------
module muldiv_unit #(
   parameter int Dbits = 32
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic [Dbits-1:0] a_i,
   input  logic [Dbits-1:0] b_i,
   input  logic             hi_we_i,
   input  logic             lo_we_i,
   input  logic [Dbits-1:0] wdata_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [Dbits-1:0] hi_o,
   output logic [Dbits-1:0] lo_o
);

   localparam int CW = $clog2(Dbits) + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [CW-1:0]    count_q, count_d;
   logic             res_neg_q, res_neg_d;   // product / quotient must be negated
   logic [Dbits-1:0] mcand_q, mcand_d;       // |B|: multiplicand or divisor
   logic [Dbits:0]   acc_q, acc_d;           // upper product half / partial remainder
   logic [Dbits-1:0] low_q, low_d;           // multiplier bits out, quotient bits in
   logic [Dbits-1:0] hi_q, hi_d;
   logic [Dbits-1:0] lo_q, lo_d;

   logic             start_ok_s;
   logic             a_neg_s, b_neg_s;
   logic [Dbits-1:0] a_mag_s, b_mag_s;
   logic [Dbits:0]   mul_sum_s;
   logic [2*Dbits-1:0] prod_s, prod_fix_s;
   logic [Dbits-1:0] res_hi_s, res_lo_s;

   // Signed ops take magnitudes at launch; unsigned ops pass straight through.
   assign a_neg_s  = ~op_i[0] & a_i[Dbits-1];
   assign b_neg_s  = ~op_i[0] & b_i[Dbits-1];
   assign a_mag_s  = a_neg_s ? (-a_i) : a_i;
   assign b_mag_s  = b_neg_s ? (-b_i) : b_i;

   // acc_q[Dbits] is always zero while multiplying, so this cannot overflow.
   assign mul_sum_s  = acc_q + {1'b0, (low_q[0] ? mcand_q : {Dbits{1'b0}})};
   assign prod_s     = {acc_q[Dbits-1:0], low_q};
   assign prod_fix_s = res_neg_q ? (-prod_s) : prod_s;

`ifdef MULDIV_DIV_EN
   logic             div_q, div_d;           // operation is a divide
   logic             rem_neg_q, rem_neg_d;   // remainder follows the dividend sign
   logic             dz_q, dz_d;             // divisor was zero
   logic [Dbits-1:0] a_q, a_d;               // dividend as latched, for divide by zero
   logic [Dbits:0]   div_shift_s;
   logic [Dbits+1:0] div_diff_s;
   logic [Dbits-1:0] quot_fix_s, rem_fix_s;

   assign start_ok_s  = start_i;
   assign div_shift_s = {acc_q[Dbits-1:0], low_q[Dbits-1]};
   assign div_diff_s  = {1'b0, div_shift_s} - {2'b00, mcand_q};
   assign quot_fix_s  = res_neg_q ? (-low_q) : low_q;
   assign rem_fix_s   = rem_neg_q ? (-acc_q[Dbits-1:0]) : acc_q[Dbits-1:0];

   // Final HI/LO selection; divide by zero bypasses sign correction.
   always_comb begin
      res_hi_s = prod_fix_s[2*Dbits-1:Dbits];
      res_lo_s = prod_fix_s[Dbits-1:0];
      if (!div_q) begin
         res_hi_s = prod_fix_s[2*Dbits-1:Dbits];
         res_lo_s = prod_fix_s[Dbits-1:0];
      end else if (dz_q) begin
         res_hi_s = a_q;
         res_lo_s = {Dbits{1'b1}};
      end else begin
         res_hi_s = rem_fix_s;
         res_lo_s = quot_fix_s;
      end
   end

   // Divide-only launch state.
   always_comb begin
      div_d     = div_q;
      rem_neg_d = rem_neg_q;
      dz_d      = dz_q;
      a_d       = a_q;
      if ((state_q == S_IDLE) && start_ok_s) begin
         div_d     = op_i[1];
         rem_neg_d = a_neg_s;
         dz_d      = (b_i == {Dbits{1'b0}});
         a_d       = a_i;
      end else begin
         div_d     = div_q;
         rem_neg_d = rem_neg_q;
         dz_d      = dz_q;
         a_d       = a_q;
      end
   end

   // Divide-only registers.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         div_q     <= 1'b0;
         rem_neg_q <= 1'b0;
         dz_q      <= 1'b0;
         a_q       <= {Dbits{1'b0}};
      end else begin
         div_q     <= div_d;
         rem_neg_q <= rem_neg_d;
         dz_q      <= dz_d;
         a_q       <= a_d;
      end
   end
`else
   assign start_ok_s = start_i & ~op_i[1];
   assign res_hi_s   = prod_fix_s[2*Dbits-1:Dbits];
   assign res_lo_s   = prod_fix_s[Dbits-1:0];
`endif

   // Next-state, datapath iteration and HI/LO update.
   always_comb begin
      state_d   = state_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      count_d   = count_q;
      res_neg_d = res_neg_q;
      mcand_d   = mcand_q;
      acc_d     = acc_q;
      low_d     = low_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      case (state_q)
         S_IDLE: begin
            if (start_ok_s) begin
               // An accepted start wins over any MTHI/MTLO in the same cycle.
               state_d   = S_RUN;
               busy_d    = 1'b1;
               count_d   = {CW{1'b0}};
               res_neg_d = a_neg_s ^ b_neg_s;
               mcand_d   = b_mag_s;
               acc_d     = {(Dbits+1){1'b0}};
               low_d     = a_mag_s;
            end else begin
               busy_d = 1'b0;
               if (hi_we_i) hi_d = wdata_i;
               else         hi_d = hi_q;
               if (lo_we_i) lo_d = wdata_i;
               else         lo_d = lo_q;
            end
         end
         S_RUN: begin
            count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
            if (count_q == CW'(Dbits-1)) state_d = S_FIX;
            else                         state_d = S_RUN;
`ifdef MULDIV_DIV_EN
            if (div_q) begin
               // Restoring step: keep the trial difference when it did not borrow.
               if (!div_diff_s[Dbits+1]) begin
                  acc_d = div_diff_s[Dbits:0];
                  low_d = {low_q[Dbits-2:0], 1'b1};
               end else begin
                  acc_d = div_shift_s;
                  low_d = {low_q[Dbits-2:0], 1'b0};
               end
            end else begin
               acc_d = {1'b0, mul_sum_s[Dbits:1]};
               low_d = {mul_sum_s[0], low_q[Dbits-1:1]};
            end
`else
            acc_d = {1'b0, mul_sum_s[Dbits:1]};
            low_d = {mul_sum_s[0], low_q[Dbits-1:1]};
`endif
         end
         S_FIX: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            hi_d    = res_hi_s;
            lo_d    = res_lo_s;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= S_IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         count_q   <= {CW{1'b0}};
         res_neg_q <= 1'b0;
         mcand_q   <= {Dbits{1'b0}};
         acc_q     <= {(Dbits+1){1'b0}};
         low_q     <= {Dbits{1'b0}};
         hi_q      <= {Dbits{1'b0}};
         lo_q      <= {Dbits{1'b0}};
      end else begin
         state_q   <= state_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         count_q   <= count_d;
         res_neg_q <= res_neg_d;
         mcand_q   <= mcand_d;
         acc_q     <= acc_d;
         low_q     <= low_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign busy_o = busy_q;
   assign done_o = done_q;
   assign hi_o   = hi_q;
   assign lo_o   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit -- self-checking bench for muldiv_unit (Dbits = 32).
// Directed cases plus randomized multiplies (and divides when
// MULDIV_DIV_EN is defined) against a plain-arithmetic reference model.
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;

   localparam int DW = 32;

   logic          clk_s = 1'b0;
   logic          reset_s = 1'b1;
   logic          start_s = 1'b0;
   logic [1:0]    op_s = 2'b00;
   logic [DW-1:0] a_s = '0;
   logic [DW-1:0] b_s = '0;
   logic          hi_we_s = 1'b0;
   logic          lo_we_s = 1'b0;
   logic [DW-1:0] wdata_s = '0;
   logic          busy_s;
   logic          done_s;
   logic [DW-1:0] hi_s;
   logic [DW-1:0] lo_s;

   int            total = 0;
   int            bad = 0;
   logic [DW-1:0] exp_hi = '0;
   logic [DW-1:0] exp_lo = '0;

   muldiv_unit #(.Dbits(DW)) dut (
      .clk_i   (clk_s),
      .reset_i (reset_s),
      .start_i (start_s),
      .op_i    (op_s),
      .a_i     (a_s),
      .b_i     (b_s),
      .hi_we_i (hi_we_s),
      .lo_we_i (lo_we_s),
      .wdata_i (wdata_s),
      .busy_o  (busy_s),
      .done_o  (done_s),
      .hi_o    (hi_s),
      .lo_o    (lo_s)
   );

   always #5 clk_s = ~clk_s;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference result {hi, lo} from the arithmetic definition of each op.
   function automatic logic [63:0] ref_model(input logic [1:0] t_op, input logic [31:0] a, input logic [31:0] b);
      int            sa, sb, q, r;
      longint        p;
      logic [63:0]   ua, ub;
      logic [31:0]   qv, rv;
      sa = a;
      sb = b;
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (t_op)
         2'b00: begin
            p = longint'(sa) * longint'(sb);
            return p;
         end
         2'b01: return ua * ub;
         2'b10: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, a};
            q = sa / sb;
            r = sa % sb;
            qv = q;
            rv = r;
            return {rv, qv};
         end
         default: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
      endcase
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0: return 32'h8000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   // Present a start request for one edge, then scramble the operand inputs.
   task automatic launch(input logic [1:0] t_op, input logic [31:0] a, input logic [31:0] b);
      start_s = 1'b1;
      op_s    = t_op;
      a_s     = a;
      b_s     = b;
      @(negedge clk_s);
      start_s = 1'b0;
      a_s     = $urandom;
      b_s     = $urandom;
   endtask

   // Wait for done (bounded), checking busy, HI/LO hold, latency and result.
   // lat0 is the number of edges already elapsed since the start edge.
   task automatic finish_op(input string tag, input logic [1:0] t_op, input logic [31:0] a,
                            input logic [31:0] b, input int lat0);
      logic [63:0] r;
      int          lat, busy_low, hold_bad;
      bit          seen;
      r = ref_model(t_op, a, b);
      lat = lat0;
      busy_low = 0;
      hold_bad = 0;
      seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (done_s) begin
            seen = 1'b1;
            break;
         end
         if (!busy_s) busy_low++;
         if (hi_s !== exp_hi || lo_s !== exp_lo) hold_bad++;
         @(negedge clk_s);
         lat++;
      end
      check_val({tag, "_done_seen"}, 64'(seen), 64'd1);
      if (seen) begin
         check_val({tag, "_latency"}, 64'(lat), 64'(DW + 1));
         check_val({tag, "_busy_in_done"}, 64'(busy_s), 64'd0);
         check_val({tag, "_busy_gap"}, 64'(busy_low), 64'd0);
         check_val({tag, "_hold"}, 64'(hold_bad), 64'd0);
         check_val({tag, "_hilo"}, {hi_s, lo_s}, r);
      end
      exp_hi = r[63:32];
      exp_lo = r[31:0];
   endtask

   task automatic run_op(input string tag, input logic [1:0] t_op, input logic [31:0] a, input logic [31:0] b);
      launch(t_op, a, b);
      finish_op(tag, t_op, a, b, 0);
   endtask

   initial begin
      logic [31:0] ra, rb, wd;
      logic [1:0]  rop;
      int          cnt;

      // Reset
      repeat (3) @(negedge clk_s);
      check_val("rst_busy", 64'(busy_s), 64'd0);
      check_val("rst_done", 64'(done_s), 64'd0);
      check_val("rst_hilo", {hi_s, lo_s}, 64'd0);
      reset_s = 1'b0;
      @(negedge clk_s);

      // MULT with latency check, then the done pulse must drop
      run_op("mult_dir", 2'b00, 32'hFFFF_FFFE, 32'h0000_0003);
      check_val("mult_dir_const", {hi_s, lo_s}, 64'hFFFF_FFFF_FFFF_FFFA);
      @(negedge clk_s);
      check_val("done_pulse_width", 64'(done_s), 64'd0);

      // Back-to-back MULTU started in the done cycle
      run_op("multu_b2b1", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check_val("multu_b2b1_const", {hi_s, lo_s}, 64'hFFFF_FFFE_0000_0001);
      run_op("multu_b2b2", 2'b01, 32'd2, 32'd3);
      check_val("multu_b2b2_const", {hi_s, lo_s}, 64'h0000_0000_0000_0006);
      @(negedge clk_s);

      // MTHI, MTLO, both together
      hi_we_s = 1'b1; wdata_s = 32'hDEAD_BEEF;
      @(negedge clk_s);
      hi_we_s = 1'b0;
      exp_hi = 32'hDEAD_BEEF;
      check_val("mthi", {hi_s, lo_s}, {exp_hi, exp_lo});
      lo_we_s = 1'b1; wdata_s = 32'h1357_9BDF;
      @(negedge clk_s);
      lo_we_s = 1'b0;
      exp_lo = 32'h1357_9BDF;
      check_val("mtlo", {hi_s, lo_s}, {exp_hi, exp_lo});
      hi_we_s = 1'b1; lo_we_s = 1'b1; wdata_s = 32'hA5A5_0F0F;
      @(negedge clk_s);
      hi_we_s = 1'b0; lo_we_s = 1'b0;
      exp_hi = 32'hA5A5_0F0F; exp_lo = 32'hA5A5_0F0F;
      check_val("mthi_mtlo", {hi_s, lo_s}, {exp_hi, exp_lo});

      // Accepted start drops a simultaneous MTHI/MTLO
      hi_we_s = 1'b1; lo_we_s = 1'b1; wdata_s = 32'h0000_55AA;
      launch(2'b01, 32'h0001_0000, 32'h0001_0000);
      hi_we_s = 1'b0; lo_we_s = 1'b0;
      check_val("start_wins", {hi_s, lo_s}, {exp_hi, exp_lo});
      finish_op("start_wins_op", 2'b01, 32'h0001_0000, 32'h0001_0000, 0);
      @(negedge clk_s);

      // MTLO and start asserted mid-operation are ignored
      ra = $urandom; rb = $urandom;
      launch(2'b01, ra, rb);
      repeat (4) @(negedge clk_s);
      start_s = 1'b1; op_s = 2'b00; a_s = $urandom; b_s = $urandom;
      lo_we_s = 1'b1; hi_we_s = 1'b1; wdata_s = 32'hCAFE_F00D;
      @(negedge clk_s);
      start_s = 1'b0; lo_we_s = 1'b0; hi_we_s = 1'b0;
      check_val("busy_write_ignored", {hi_s, lo_s}, {exp_hi, exp_lo});
      finish_op("busy_ignore_op", 2'b01, ra, rb, 5);
      @(negedge clk_s);

      // Randomized multiplies, some back-to-back
      for (int i = 0; i < 24; i++) begin
         rop = {1'b0, 1'($urandom_range(0, 1))};
         ra = pick_operand();
         rb = pick_operand();
         run_op(rop[0] ? "rnd_multu" : "rnd_mult", rop, ra, rb);
         if ($urandom_range(0, 1) == 0) @(negedge clk_s);
      end
      @(negedge clk_s);

`ifdef MULDIV_DIV_EN
      run_op("div_dir1", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
      check_val("div_dir1_const", {hi_s, lo_s}, 64'hFFFF_FFFF_FFFF_FFFD);
      run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
      check_val("div_ovf_const", {hi_s, lo_s}, 64'h0000_0000_8000_0000);
      run_op("divu_zero", 2'b11, 32'h1234_5678, 32'd0);
      check_val("divu_zero_const", {hi_s, lo_s}, 64'h1234_5678_FFFF_FFFF);
      run_op("div_zero_neg", 2'b10, 32'hFFFF_FF00, 32'd0);
      @(negedge clk_s);
      for (int i = 0; i < 24; i++) begin
         rop = {1'b1, 1'($urandom_range(0, 1))};
         ra = pick_operand();
         rb = ($urandom_range(0, 7) == 0) ? 32'd0 : pick_operand();
         run_op(rop[0] ? "rnd_divu" : "rnd_div", rop, ra, rb);
         if ($urandom_range(0, 1) == 0) @(negedge clk_s);
      end
      @(negedge clk_s);
`else
      // Divide ops are not accepted: no busy, no done, HI/LO untouched
      launch(2'b11, 32'h1234_5678, 32'd0);
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (busy_s || done_s) cnt++;
         @(negedge clk_s);
      end
      check_val("nodiv_quiet", 64'(cnt), 64'd0);
      check_val("nodiv_hilo", {hi_s, lo_s}, {exp_hi, exp_lo});
      // A rejected divide start leaves MTHI free to load
      start_s = 1'b1; op_s = 2'b10; hi_we_s = 1'b1; wdata_s = 32'h0BAD_F00D;
      @(negedge clk_s);
      start_s = 1'b0; hi_we_s = 1'b0;
      exp_hi = 32'h0BAD_F00D;
      check_val("nodiv_mthi", {hi_s, lo_s}, {exp_hi, exp_lo});
      check_val("nodiv_mthi_busy", 64'(busy_s), 64'd0);
`endif

      // Reset at the cycle-10 edge of a MULTU aborts it
      launch(2'b01, 32'hFFFF_FFFF, 32'h0000_0007);
      repeat (9) @(negedge clk_s);
      reset_s = 1'b1;
      @(negedge clk_s);
      reset_s = 1'b0;
      check_val("abort_busy", 64'(busy_s), 64'd0);
      check_val("abort_hilo", {hi_s, lo_s}, 64'd0);
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (done_s) cnt++;
         @(negedge clk_s);
      end
      check_val("abort_no_done", 64'(cnt), 64'd0);
      exp_hi = '0; exp_lo = '0;

      // Unit still works after the abort
      run_op("post_abort", 2'b00, 32'h7FFF_FFFF, 32'h8000_0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
